// File: rtl/dct_quant_zigzag_ser.sv
// rtl/dct_quant_zigzag_ser.sv - JPEG luminance quantizer with zigzag serializer; QUANT_ROUND_EN selects round-half-away rounding
module dct_quant_zigzag_ser #(
    parameter int IN_W  = 32,
    parameter int FRAC  = 8,
    parameter int OUT_W = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [64*IN_W-1:0]      in_block,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] out_coef,
    output logic [5:0]              out_idx,
    output logic                    out_last,
    input  logic                    out_ready
);
    localparam int PW = IN_W + 18;
    localparam int S  = FRAC + 16;

    // Tables are listed in natural order, so entry i lives at slot (63-i).
    localparam logic [64*8-1:0] QTAB = {
        8'd16, 8'd11, 8'd10, 8'd16, 8'd24, 8'd40, 8'd51, 8'd61,
        8'd12, 8'd12, 8'd14, 8'd19, 8'd26, 8'd58, 8'd60, 8'd55,
        8'd14, 8'd13, 8'd16, 8'd24, 8'd40, 8'd57, 8'd69, 8'd56,
        8'd14, 8'd17, 8'd22, 8'd29, 8'd51, 8'd87, 8'd80, 8'd62,
        8'd18, 8'd22, 8'd37, 8'd56, 8'd68, 8'd109, 8'd103, 8'd77,
        8'd24, 8'd35, 8'd55, 8'd64, 8'd81, 8'd104, 8'd113, 8'd92,
        8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
        8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99};

    localparam logic [64*6-1:0] ZZ = {
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63};

    // RECIP entry i (raster index) sits at bits [i*17 +: 17].
    function automatic logic [64*17-1:0] make_recip();
        logic [64*17-1:0] r;
        int q;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            q = int'(QTAB[(63-i)*8 +: 8]);
            r[i*17 +: 17] = 17'((65536 + q / 2) / q);
        end
        return r;
    endfunction

    localparam logic [64*17-1:0] RECIP = make_recip();

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_n;

    logic [64*IN_W-1:0]      blk;
    logic [6:0]              k;
    logic                    issuing, advance;
    logic [5:0]              zz;
    logic signed [IN_W-1:0]  coef;
    logic signed [17:0]      recip;
    logic                    a_valid;
    logic signed [PW-1:0]    a_prod;
    logic [5:0]              a_idx;
    logic                    neg;
    logic [PW-1:0]           abs_v;
    logic [PW:0]             mag, shifted, lim;
    logic [OUT_W-1:0]        coef_n;

    assign in_ready = rst_n && (state == IDLE);
    assign issuing  = (state == RUN) && !k[6];
    assign advance  = !out_valid || out_ready;

    assign zz    = ZZ[(6'd63 - k[5:0])*6 +: 6];
    assign coef  = blk[zz*IN_W +: IN_W];
    assign recip = {1'b0, RECIP[zz*17 +: 17]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (in_valid) state_n = RUN;
            RUN:  if (out_valid && out_ready && out_last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) blk <= in_block;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k       <= '0;
            a_valid <= 1'b0;
            a_prod  <= '0;
            a_idx   <= '0;
        end else if (state == IDLE && in_valid) begin
            k <= '0;
        end else if (advance) begin
            a_valid <= issuing;
            if (issuing) begin
                a_prod <= PW'(coef) * PW'(recip);
                a_idx  <= k[5:0];
                k      <= k + 7'd1;
            end
        end
    end

    // Sign-magnitude shift so both rounding modes are symmetric about zero.
    always_comb begin
        neg   = a_prod[PW-1];
        abs_v = neg ? (-a_prod) : a_prod;
`ifdef QUANT_ROUND_EN
        mag   = {1'b0, abs_v} + ((PW+1)'(1) << (S-1));
`else
        mag   = {1'b0, abs_v};
`endif
        shifted = mag >> S;
        lim     = {{(PW-OUT_W+1){1'b0}}, 1'b1, {(OUT_W-1){1'b0}}};
        if (!neg)
            coef_n = (shifted >= lim) ? {1'b0, {(OUT_W-1){1'b1}}} : shifted[OUT_W-1:0];
        else
            coef_n = (shifted >= lim) ? {1'b1, {(OUT_W-1){1'b0}}} : (~shifted[OUT_W-1:0] + 1'b1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_coef  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else if (advance) begin
            out_valid <= a_valid;
            if (a_valid) begin
                out_coef <= coef_n;
                out_idx  <= a_idx;
                out_last <= (a_idx == 6'd63);
            end
        end
    end
endmodule

// File: tb/tb_dct_quant_zigzag_ser.sv
// tb/tb_dct_quant_zigzag_ser.sv - directed and randomized-stall bench for dct_quant_zigzag_ser
module tb_dct_quant_zigzag_ser;
    localparam int IN_W  = 32;
    localparam int OUT_W = 12;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    in_valid = 1'b0;
    logic [64*IN_W-1:0]      in_block = '0;
    logic                    in_ready;
    logic                    out_valid;
    logic signed [OUT_W-1:0] out_coef;
    logic [5:0]              out_idx;
    logic                    out_last;
    logic                    out_ready = 1'b0;

    dct_quant_zigzag_ser #(.IN_W(IN_W), .FRAC(8), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_block(in_block),
        .in_ready(in_ready), .out_valid(out_valid), .out_coef(out_coef),
        .out_idx(out_idx), .out_last(out_last), .out_ready(out_ready));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int tests = 0;
    int fails = 0;

    int qtab[64] = '{16, 11, 10, 16, 24, 40, 51, 61, 12, 12, 14, 19, 26, 58, 60, 55,
                     14, 13, 16, 24, 40, 57, 69, 56, 14, 17, 22, 29, 51, 87, 80, 62,
                     18, 22, 37, 56, 68, 109, 103, 77, 24, 35, 55, 64, 81, 104, 113, 92,
                     49, 64, 78, 87, 103, 121, 120, 101, 72, 92, 95, 98, 112, 100, 103, 99};
    int zzt[64] = '{0, 1, 8, 16, 9, 2, 3, 10, 17, 24, 32, 25, 18, 11, 4, 5,
                    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13, 6, 7, 14, 21, 28,
                    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
                    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

    typedef struct {
        int pos;
        int raw;
        int idx;
        int coef_rnd;
        int coef_trunc;
    } vec_t;
    vec_t vecs[8];

    int got_coef[64], got_idx[64], got_last[64];
    int n_got, t_acc, t_first, t_last, ready_viol, stab_viol;
    int expc[64];
    int raws[3][64];
    logic [64*IN_W-1:0] rblk[3];

    task automatic check(input string name, input longint got, input longint exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_q(input int raw, input int q);
        longint r, p, m;
        r = longint'((65536 + q / 2) / q);
        p = longint'(raw) * r;
        m = (p < 0) ? -p : p;
`ifdef QUANT_ROUND_EN
        m = m + (longint'(1) << 23);
`endif
        m = m >> 24;
        if (p < 0) m = -m;
        if (m > 2047) m = 2047;
        if (m < -2048) m = -2048;
        return int'(m);
    endfunction

    task automatic send(input logic [64*IN_W-1:0] b);
        int w;
        in_block = b;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 300) begin
            tick();
            w++;
        end
        if (!in_ready) check("send_timeout", 0, 1);
        tick();
        t_acc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic collect(input bit stall, input bit nv, input logic [64*IN_W-1:0] nb,
                           input int stop_idx);
        bit held;
        int hc, hi, hl, budget;
        n_got = 0; t_first = -1; t_last = -1;
        ready_viol = 0; stab_viol = 0; held = 0; budget = 0;
        hc = 0; hi = 0; hl = 0;
        in_valid = nv;
        in_block = nb;
        while (n_got < 64 && budget < 2000) begin
            if (held && (!out_valid || int'(out_coef) != hc || int'(out_idx) != hi
                         || int'(out_last) != hl))
                stab_viol++;
            if (in_ready) ready_viol++;
            if (out_valid && stop_idx >= 0 && int'(out_idx) == stop_idx) return;
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && t_first < 0) t_first = cyc;
            if (out_valid && out_ready) begin
                got_coef[n_got] = int'(out_coef);
                got_idx[n_got]  = int'(out_idx);
                got_last[n_got] = int'(out_last);
                if (out_last) t_last = cyc;
                n_got++;
            end
            held = out_valid && !out_ready;
            hc = int'(out_coef); hi = int'(out_idx); hl = int'(out_last);
            tick();
            budget++;
        end
        if (n_got < 64) check("collect_timeout", n_got, 64);
        out_ready = 1'b1;
    endtask

    task automatic verify(input string tag, input int exp[64]);
        int idx_err, last_err, coef_err, bad_k;
        idx_err = 0; last_err = 0; coef_err = 0; bad_k = -1;
        for (int i = 0; i < n_got; i++) begin
            if (got_idx[i] != i) idx_err++;
            if (got_last[i] != ((i == 63) ? 1 : 0)) last_err++;
            if (got_coef[i] != exp[i]) begin
                coef_err++;
                if (bad_k < 0) bad_k = i;
            end
        end
        check({tag, "_count"}, n_got, 64);
        check({tag, "_idx_order_errors"}, idx_err, 0);
        check({tag, "_last_errors"}, last_err, 0);
        if (bad_k >= 0) check({tag, "_coef_first_bad"}, got_coef[bad_k], exp[bad_k]);
        else check({tag, "_coef_errors"}, coef_err, 0);
        check({tag, "_stable_while_stalled"}, stab_viol, 0);
        check({tag, "_in_ready_low_in_run"}, ready_viol, 0);
    endtask

    initial begin
        logic [64*IN_W-1:0] b;
        vecs[0] = '{pos: 0,  raw: 32'h0004_0000, idx: 0,  coef_rnd: 64,    coef_trunc: 64};
        vecs[1] = '{pos: 8,  raw: 30720,         idx: 2,  coef_rnd: 10,    coef_trunc: 9};
        vecs[2] = '{pos: 1,  raw: -25600,        idx: 1,  coef_rnd: -9,    coef_trunc: -9};
        vecs[3] = '{pos: 0,  raw: 2048,          idx: 0,  coef_rnd: 1,     coef_trunc: 0};
        vecs[4] = '{pos: 0,  raw: -2048,         idx: 0,  coef_rnd: -1,    coef_trunc: 0};
        vecs[5] = '{pos: 0,  raw: 10240000,      idx: 0,  coef_rnd: 2047,  coef_trunc: 2047};
        vecs[6] = '{pos: 0,  raw: -10240000,     idx: 0,  coef_rnd: -2048, coef_trunc: -2048};
        vecs[7] = '{pos: 7,  raw: -156160,       idx: 28, coef_rnd: -10,   coef_trunc: -9};

        repeat (3) tick();
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_coef", out_coef, 0);
        check("reset_out_idx", out_idx, 0);
        check("reset_out_last", out_last, 0);
        rst_n = 1'b1;
        tick();
        check("in_ready_after_reset", in_ready, 1);

        for (int v = 0; v < 8; v++) begin
            b = '0;
            b[vecs[v].pos*IN_W +: IN_W] = vecs[v].raw;
            for (int i = 0; i < 64; i++) expc[i] = 0;
`ifdef QUANT_ROUND_EN
            expc[vecs[v].idx] = vecs[v].coef_rnd;
`else
            expc[vecs[v].idx] = vecs[v].coef_trunc;
`endif
            send(b);
            collect(1'b0, 1'b0, b, -1);
            verify($sformatf("vec%0d", v), expc);
            if (v == 0) begin
                check("latency_first", t_first - t_acc, 2);
                check("latency_last", t_last - t_acc, 65);
            end
            check($sformatf("vec%0d_in_ready_after_last", v), in_ready, 1);
        end

        for (int j = 0; j < 3; j++) begin
            rblk[j] = '0;
            for (int i = 0; i < 64; i++) begin
                raws[j][i] = int'($urandom_range(0, 2097152)) - 1048576;
                rblk[j][i*IN_W +: IN_W] = raws[j][i];
            end
        end
        for (int j = 0; j < 3; j++) begin
            send(rblk[j]);
            collect(1'b1, (j < 2), (j < 2) ? rblk[(j+1) % 3] : '0, -1);
            for (int i = 0; i < 64; i++) expc[i] = model_q(raws[j][zzt[i]], qtab[zzt[i]]);
            verify($sformatf("rand%0d", j), expc);
        end
        in_valid = 1'b0;
        tick();
        check("in_ready_after_random", in_ready, 1);

        b = '0;
        b[0 +: IN_W] = 32'h0004_0000;
        send(b);
        collect(1'b0, 1'b0, b, 30);
        check("mid_block_reached_k30", out_idx, 30);
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", out_valid, 0);
        check("midreset_out_idx", out_idx, 0);
        check("midreset_in_ready", in_ready, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("postreset_in_ready", in_ready, 1);
        check("postreset_out_valid", out_valid, 0);
        b = '0;
        b[8*IN_W +: IN_W] = 30720;
        for (int i = 0; i < 64; i++) expc[i] = 0;
`ifdef QUANT_ROUND_EN
        expc[2] = 10;
`else
        expc[2] = 9;
`endif
        send(b);
        collect(1'b0, 1'b0, b, -1);
        verify("after_reset", expc);
        check("after_reset_latency", t_first - t_acc, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dct_quant_zigzag_ser.md
# dct_quant_zigzag_ser

Downstream consumer of the pipelined 8×8 2-D DCT block. It accepts one 64-word coefficient block over a block-level valid/ready handshake and quantizes each coefficient against the fixed JPEG luminance table (Annex K, Table K.1). It then streams the 64 results out one per cycle in zigzag order, with full backpressure, to the entropy-coding stage.

## Interface
- IN_W, 32: input coefficient word width, signed fixed point.
- FRAC, 8: fractional bits of input words.
- OUT_W, 12: output quantized coefficient width, signed integer.
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_block holds a valid DCT block.
- in_block  in  64*IN_W  raster-order block; word i at bits [i*IN_W +: IN_W], i = row*8+col.
- in_ready  out  1  block accepted on the cycle where in_valid && in_ready.
- out_valid  out  1  out_coef / out_idx / out_last valid.
- out_coef  out  OUT_W  quantized coefficient, signed.
- out_idx  out  6  zigzag position k (0..63) of out_coef.
- out_last  out  1  high with k = 63.
- out_ready  in  1  downstream accepts on out_valid && out_ready.

## Operation
- States: IDLE, RUN. Reset → IDLE.
- IDLE: in_ready=1. On in_valid, capture in_block into a 64×IN_W buffer, clear k=0, go RUN.
- RUN: in_ready=0. The block issues k = 0..63 into a 2-stage pipeline. Stage A selects buf[ZZ[k]] (standard JPEG zigzag: ZZ = 0,1,8,16,9,2,3,10,…,63) and registers coef × RECIP[ZZ[k]].
- RECIP[i] = round(2^16 / Q[i]), 17-bit unsigned constant, computed at elaboration. Product is signed IN_W+18 bits.
- Stage B: shift the product magnitude right by S = FRAC+16 with the rounding mode from Configuration, and reapply the sign. Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1], then register into out_coef/out_idx/out_last with out_valid=1.
- Pipeline advances only when the stage-B register is empty or being consumed (!out_valid || out_ready). Otherwise all stages and k hold.
- After k=63 is issued, issuing stops. On the handshake with out_last=1, state → IDLE. in_ready=1 from the next cycle.
- Buffer is not overwritten during RUN. in_valid during RUN is ignored (not consumed).

## Timing
- Reset values: in_ready=0 during reset, 1 in the first cycle after release. out_valid=0, out_coef=0, out_idx=0, out_last=0.
- Latency: with out_ready=1, in-handshake at cycle T gives first out_valid at T+2 (k=0) and last at T+65. The next in_ready is at T+66.
- Throughput: 1 coefficient/cycle without backpressure; 66 cycles/block minimum.
- With out_ready=0, out_coef/out_idx/out_last are held stable and no coefficient is lost or duplicated.
- Reset asserted mid-block: immediate return to IDLE with outputs at reset values. The partial block is discarded.
- Simultaneous events: none possible. in_valid is sampled only in IDLE, and out_valid is 0 in IDLE.

## Configuration
- QUANT_ROUND_EN defined: round half away from zero. Add 2^(S-1) to the magnitude before the shift.
- QUANT_ROUND_EN undefined: truncate toward zero (plain magnitude shift).
- Saturation, ordering and timing are identical in both builds.

## Test plan
- All-zero block except raster word 0 = 0x00040000 (1024.0), out_ready=1 → out_idx 0 gives 64, then 63 zeros. out_last is high only at idx 63. First out_valid 2 cycles after accept.
- Raster word 8 = 120.0 (0x00007800, Q=12), all else 0 → single nonzero out_coef=10 at out_idx=2. Raster word 1 = -100.0 (Q=11) → -9 at out_idx=1.
- Raster word 0 = 8.0 (0x00000800) → out_coef=1 with QUANT_ROUND_EN, 0 without. Raster word 0 = -8.0 → -1 with, 0 without.
- Raster word 0 = 40000.0 → 2047. Raster word 0 = -40000.0 → -2048 (saturation).
- Random out_ready toggling (50%) over 3 back-to-back random blocks → sequence matches the golden model. Outputs are stable while stalled. in_ready stays 0 until out_last is handshaken.
- rst_n pulsed low at k=30 → out_valid=0 immediately. The next block is processed from k=0 with correct values.
